vram_scanout: RTL
=================

Name: vram_scanout

Overview:
- Video scanout stage that sits directly downstream of the dual-port video RAM. It drives the RAM's read-only second port (address out, data in, combinational read) to fetch the 1-bpp framebuffer.
- Serialises each fetched byte LSB-first into pixels and generates raster timing (hsync/vsync/active).
- Raises the mid-screen and end-of-screen interrupt requests consumed by the CPU interrupt logic.
- Native (unrotated) raster: 256 pixels × 224 lines, 32 bytes per line.

Parameters:
- H_ACTIVE, 256, visible pixels per line (multiple of 8).
- H_TOTAL, 320, pixel ticks per line.
- HSYNC_START, 272, first x with hsync asserted.
- HSYNC_END, 304, first x after hsync.
- V_ACTIVE, 224, visible lines.
- V_TOTAL, 262, lines per frame.
- VSYNC_START, 234, first y with vsync asserted.
- VSYNC_END, 237, first y after vsync.
- MID_LINE, 96, line whose start raises irq_mid.
- VRAM_ADDR_WIDTH, 13, width of vram_addr.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- pix_ce, input, 1, pixel-tick enable; all counters and registered outputs advance only when high.
- vram_addr, output, VRAM_ADDR_WIDTH, RAM read address = y*32 + x[7:3]; combinational from counters; 0 outside active area.
- vram_data, input, 8, RAM read data, valid in the same cycle as vram_addr.
- pixel, output, 1, current monochrome pixel; 0 outside active area.
- pixel_rgb, output, 3, {r,g,b} pixel colour (see Optional Feature).
- de, output, 1, display enable (active area).
- hsync, output, 1, horizontal sync, active-high.
- vsync, output, 1, vertical sync, active-high.
- irq_mid, output, 1, one-clk pulse at the start of MID_LINE.
- irq_vblank, output, 1, one-clk pulse at the start of line V_ACTIVE.

Behaviour:
- Decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Counters: x in [0, H_TOTAL-1], y in [0, V_TOTAL-1]. On a clk edge with pix_ce=1:
  - x increments;
  - at x = H_TOTAL-1, x wraps to 0 and y increments;
  - at y = V_TOTAL-1 with x wrapping, y wraps to 0.
- No state changes when pix_ce=0; all outputs hold, and irq pulses drop to 0.
- Reset: x=y=0; pixel, pixel_rgb, de, hsync, vsync, irq_mid, irq_vblank all 0; shift register 0.
  - Reset mid-frame restarts at (0,0) on the next tick.
  - No irq is issued in a cycle where rst=1.
- Latency: all outputs except vram_addr are registered. On a tick edge they reflect the position (x,y) held before that edge, a fixed 1-tick latency common to all of them, so syncs, de and pixel stay mutually aligned.
- Active area: active = (x < H_ACTIVE) && (y < V_ACTIVE).
- Fetch (active, x[2:0]=0): shift register loads vram_data; pixel <= vram_data[0]; the register then shifts right.
- Shift (active, x[2:0]≠0): pixel <= the next register bit, so byte bit k appears at x = 8n+k.
- Inactive: pixel <= 0 and de <= 0.
- hsync <= (HSYNC_START ≤ x < HSYNC_END); vsync <= (VSYNC_START ≤ y < VSYNC_END).
- irq_mid <= 1 for exactly one clk on the tick where x=0 and y=MID_LINE; irq_vblank likewise at x=0, y=V_ACTIVE. Both are cleared on the next clk regardless of pix_ce.
- Address arithmetic: y[7:0]·32 + x[7:3], truncated to VRAM_ADDR_WIDTH. The maximum is 7167 at the defaults.

Optional Feature:
- Macro: SCANOUT_OVERLAY_EN.
- Defined: pixel_rgb applies the cabinet gel overlay, banded by native x, only when pixel=1:
  - x < 16: green, except for y outside [16,134) where it is white;
  - 16 ≤ x < 72: green;
  - 192 ≤ x < 224: red;
  - otherwise white (3'b111).
- Undefined: pixel_rgb = {3{pixel}}.
- pixel_rgb is registered with the same latency as pixel in both cases.

Decomposition:
- Package `video_pkg`: timing constant defaults, the colour constants COL_WHITE/COL_GREEN/COL_RED, and the VRAM geometry (BYTES_PER_LINE=32).
- One natural sub-module: `raster_counter`, holding x/y with pix_ce, the wrap logic and the active/sync decode. The serialiser, irq and overlay logic stay in the top level.

Test Plan:
1. Reset, then hold pix_ce=1 for one frame. Required: H_TOTAL·V_TOTAL = 83840 ticks between successive vsync rising edges; hsync high for 32 ticks per line; de high for 256 ticks on each of 224 lines.
2. Model RAM with byte 8'hA5 at address 0. Required: vram_addr=0 at (0,0), and pixel sequence 1,0,1,0,0,1,0,1 on the first 8 de ticks.
3. Address 33 = 8'h01. Required: vram_addr=33 at x=8, y=1, and pixel=1 only at x=8 of line 1.
4. pix_ce pulsing every 3rd clk. Required: irq_mid and irq_vblank each high for exactly 1 clk, once per frame, at y=96 and y=224; outputs stable between ticks.
5. Assert rst for 1 clk at (150,100). Required: all outputs 0 next clk; counter restarts at (0,0); no spurious irq; next irq_mid after 96 full lines.
6. With SCANOUT_OVERLAY_EN and all-ones RAM. Required: pixel_rgb=3'b010 at x=20, 3'b100 at x=200, 3'b111 at x=100; 3'b000 during blanking.

Source files
------------

// File: rtl/video_pkg.sv
// Shared timing defaults, colour codes and VRAM geometry for the video
// scanout path, plus the cabinet-overlay colour lookup.
package video_pkg;

  localparam int H_ACTIVE_DEF    = 256;
  localparam int H_TOTAL_DEF     = 320;
  localparam int HSYNC_START_DEF = 272;
  localparam int HSYNC_END_DEF   = 304;
  localparam int V_ACTIVE_DEF    = 224;
  localparam int V_TOTAL_DEF     = 262;
  localparam int VSYNC_START_DEF = 234;
  localparam int VSYNC_END_DEF   = 237;
  localparam int MID_LINE_DEF    = 96;
  localparam int VRAM_AW_DEF     = 13;

  localparam int BYTES_PER_LINE  = 32;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_RED   = 3'b100;

  // Gel bands, in native (unrotated) coordinates.
  localparam int OVL_LEFT_END    = 16;
  localparam int OVL_LEFT_Y_LO   = 16;
  localparam int OVL_LEFT_Y_HI   = 134;
  localparam int OVL_GREEN_END   = 72;
  localparam int OVL_RED_START   = 192;
  localparam int OVL_RED_END     = 224;

  // Colour of a lit pixel at (x, y) seen through the cabinet gel.
  function automatic logic [2:0] overlay_colour(input int unsigned x,
                                                input int unsigned y);
    if (x < OVL_LEFT_END)
      return (y < OVL_LEFT_Y_LO || y >= OVL_LEFT_Y_HI) ? COL_WHITE : COL_GREEN;
    if (x < OVL_GREEN_END)
      return COL_GREEN;
    if (x >= OVL_RED_START && x < OVL_RED_END)
      return COL_RED;
    return COL_WHITE;
  endfunction

endpackage

// File: rtl/vram_scanout_if.sv
// Read-only VRAM port used by the scanout stage: address out, data back in
// the same cycle (combinational RAM read).
interface vram_scanout_if #(
  parameter int ADDR_WIDTH = 13
);
  logic [ADDR_WIDTH-1:0] vram_addr;
  logic [7:0]            vram_data;

  modport master (output vram_addr, input  vram_data);
  modport slave  (input  vram_addr, output vram_data);
endinterface

// File: rtl/raster_counter.sv
// Beam position counter (x within line, y within frame) advanced by pix_ce,
// with combinational decode of active area and sync windows.
module raster_counter
  import video_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int HSYNC_START = HSYNC_START_DEF,
  parameter int HSYNC_END   = HSYNC_END_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int VSYNC_START = VSYNC_START_DEF,
  parameter int VSYNC_END   = VSYNC_END_DEF,
  localparam int XW = $clog2(H_TOTAL),
  localparam int YW = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_ce,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          active,
  output logic          hsync_c,
  output logic          vsync_c
);

  logic x_last;
  logic y_last;

  assign x_last = (x == XW'(H_TOTAL - 1));
  assign y_last = (y == YW'(V_TOTAL - 1));

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would make x and y race each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (pix_ce) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign active  = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
  assign hsync_c = (x >= XW'(HSYNC_START)) && (x < XW'(HSYNC_END));
  assign vsync_c = (y >= YW'(VSYNC_START)) && (y < YW'(VSYNC_END));

endmodule

// File: rtl/vram_scanout.sv
// 1-bpp framebuffer scanout: fetches VRAM bytes, serialises them LSB-first,
// emits registered raster timing and mid-screen / vblank interrupt pulses.
// Build option: define SCANOUT_OVERLAY_EN to colour pixel_rgb with the
// cabinet gel overlay; otherwise pixel_rgb is the pixel replicated.
module vram_scanout
  import video_pkg::*;
#(
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int H_TOTAL         = H_TOTAL_DEF,
  parameter int HSYNC_START     = HSYNC_START_DEF,
  parameter int HSYNC_END       = HSYNC_END_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int V_TOTAL         = V_TOTAL_DEF,
  parameter int VSYNC_START     = VSYNC_START_DEF,
  parameter int VSYNC_END       = VSYNC_END_DEF,
  parameter int MID_LINE        = MID_LINE_DEF,
  parameter int VRAM_ADDR_WIDTH = VRAM_AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_ce,
  vram_scanout_if.master       vram,
  output logic                 pixel,
  output logic [2:0]           pixel_rgb,
  output logic                 de,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 irq_mid,
  output logic                 irq_vblank
);

  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          active;
  logic          hsync_c;
  logic          vsync_c;

  raster_counter #(
    .H_ACTIVE    (H_ACTIVE),
    .H_TOTAL     (H_TOTAL),
    .HSYNC_START (HSYNC_START),
    .HSYNC_END   (HSYNC_END),
    .V_ACTIVE    (V_ACTIVE),
    .V_TOTAL     (V_TOTAL),
    .VSYNC_START (VSYNC_START),
    .VSYNC_END   (VSYNC_END)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .pix_ce  (pix_ce),
    .x       (x),
    .y       (y),
    .active  (active),
    .hsync_c (hsync_c),
    .vsync_c (vsync_c)
  );

  // Byte address = line * 32 + byte-within-line; held at 0 during blanking.
  logic [12:0] addr_full;
  assign addr_full     = {y[7:0], 5'b0_0000} + 13'(x[7:3]);
  assign vram.vram_addr = active ? VRAM_ADDR_WIDTH'(addr_full) : '0;

  logic [7:0] shreg;
  logic [7:0] shreg_next;
  logic       pix_next;
  logic [2:0] rgb_next;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    pix_next   = 1'b0;
    shreg_next = shreg;
    if (active) begin
      if (x[2:0] == 3'd0) begin
        pix_next   = vram.vram_data[0];
        shreg_next = {1'b0, vram.vram_data[7:1]};
      end else begin
        pix_next   = shreg[0];
        shreg_next = {1'b0, shreg[7:1]};
      end
    end
  end

`ifdef SCANOUT_OVERLAY_EN
  always_comb begin
    rgb_next = pix_next ? overlay_colour(32'(x), 32'(y)) : COL_BLACK;
  end
`else
  always_comb begin
    rgb_next = {3{pix_next}};
  end
`endif

  // Everything registered advances on the pixel tick, one tick behind the
  // counters, so syncs, de and pixel stay mutually aligned. The irq pulses
  // are cleared on every clk so they last exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      pixel      <= 1'b0;
      pixel_rgb  <= COL_BLACK;
      de         <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      irq_mid    <= 1'b0;
      irq_vblank <= 1'b0;
    end else begin
      irq_mid    <= 1'b0;
      irq_vblank <= 1'b0;
      if (pix_ce) begin
        shreg      <= shreg_next;
        pixel      <= pix_next;
        pixel_rgb  <= rgb_next;
        de         <= active;
        hsync      <= hsync_c;
        vsync      <= vsync_c;
        irq_mid    <= (x == '0) && (y == YW'(MID_LINE));
        irq_vblank <= (x == '0) && (y == YW'(V_ACTIVE));
      end
    end
  end

endmodule
